// File: rtl/ctr_pkg.sv
// ---------------------------------------------------------------------------
// ctr_pkg
//   Shared encodings for the modulo counter family.
//
//   MODE_WRAP / MODE_ONESHOT : value of the MODE input
//   DIR_DOWN  / DIR_UP       : value of the UP input
// ---------------------------------------------------------------------------
package ctr_pkg;

  localparam logic MODE_WRAP    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  localparam logic DIR_DOWN     = 1'b0;
  localparam logic DIR_UP       = 1'b1;

endpackage : ctr_pkg

// File: rtl/mod_counter_next.sv
// ---------------------------------------------------------------------------
// mod_counter_next
//   Purely combinational next-state logic for mod_counter. It owns every
//   counting rule (load clamp, wrap, one-shot stop, sticky DONE, terminal
//   carry) so that it can be exercised in isolation from the registers.
//
//   Parameters
//     WIDTH     counter width in bits
//     MAX_VAL   terminal count (counter range is 0..MAX_VAL)
//
//   Ports
//     q          in   WIDTH  current registered count
//     en         in   1      count enable
//     load       in   1      parallel load strobe (wins over en)
//     d          in   WIDTH  load value, clamped to MAX_VAL
//     up         in   1      direction (DIR_UP / DIR_DOWN)
//     mode       in   1      MODE_WRAP / MODE_ONESHOT
//     done       in   1      current registered DONE flag
//     next_q     out  WIDTH  count to be registered at the next edge
//     next_done  out  1      DONE to be registered at the next edge
//     tc         out  1      terminal-count carry for cascading
// ---------------------------------------------------------------------------
module mod_counter_next
  import ctr_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 14
) (
  input  logic [WIDTH-1:0] q,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             mode,
  input  logic             done,
  output logic [WIDTH-1:0] next_q,
  output logic             next_done,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_Q = '0;
  localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

  logic at_max;
  logic at_zero;
  logic frozen;

  assign at_max  = (q == MAX_Q);
  assign at_zero = (q == ZERO_Q);

  // High during the cycle whose edge wraps (or stops) the counter, so the
  // next cascaded stage sees exactly one enable per full lap of this one.
  assign tc = en & (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_zero));

  // A completed one-shot ignores EN until LOAD or RESET. Switching back to
  // wrap mode releases it without clearing DONE.
  assign frozen = done & (mode == MODE_ONESHOT);

  always_comb begin
    next_q    = q;
    next_done = done;
    if (load) begin
      next_q    = (d > MAX_Q) ? MAX_Q : d;
      next_done = 1'b0;
    end else if (en && !frozen) begin
      if (up == DIR_UP) begin
        // Terminal compare precedes the increment, so q + 1 never overflows.
        if (!at_max) begin
          next_q = q + ONE_Q;
        end else if (mode == MODE_WRAP) begin
          next_q = ZERO_Q;
        end else begin
          next_done = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          next_q = q - ONE_Q;
        end else if (mode == MODE_WRAP) begin
          next_q = MAX_Q;
        end else begin
          next_done = 1'b1;
        end
      end
    end
  end

endmodule : mod_counter_next

// File: rtl/mod_counter.sv
// ---------------------------------------------------------------------------
// mod_counter
//   Parametrised synchronous modulo counter (0..MAX_VAL) with enable,
//   clamped parallel load, up/down direction, wrap or one-shot mode, a
//   sticky one-shot DONE flag and a combinational terminal-count carry.
//   Instances cascade by wiring TC of one stage to EN of the next.
//
//   Parameters
//     WIDTH     counter width in bits (default 4)
//     MAX_VAL   terminal count, 1 <= MAX_VAL <= 2**WIDTH-1 (default 14)
//
//   Ports
//     CLK    in   1      clock, rising edge
//     RESET  in   1      synchronous active-low reset (Q=0, DONE=0)
//     EN     in   1      count enable
//     LOAD   in   1      parallel load strobe
//     D      in   WIDTH  load value
//     UP     in   1      1 = count up, 0 = count down
//     MODE   in   1      0 = wrap, 1 = one-shot
//     Q      out  WIDTH  registered count
//     TC     out  1      terminal-count carry (combinational from Q, EN, UP)
//     DONE   out  1      registered one-shot completion flag
// ---------------------------------------------------------------------------
module mod_counter
  import ctr_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 14
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic             UP,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             DONE
);

  localparam longint unsigned MAX_LEGAL = (64'd1 << WIDTH) - 64'd1;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_counter: WIDTH=%0d must be in 1..32", WIDTH);
  end
  if (MAX_VAL < 1 || longint'(MAX_VAL) > longint'(MAX_LEGAL)) begin : g_bad_max
    $error("mod_counter: MAX_VAL=%0d outside 1..2**WIDTH-1", MAX_VAL);
  end

  logic [WIDTH-1:0] q_p0;
  logic             done_p0;
  logic [WIDTH-1:0] next_q;
  logic             next_done;
  logic             tc;

  mod_counter_next #(
    .WIDTH   (WIDTH),
    .MAX_VAL (MAX_VAL)
  ) u_next (
    .q         (q_p0),
    .en        (EN),
    .load      (LOAD),
    .d         (D),
    .up        (UP),
    .mode      (MODE),
    .done      (done_p0),
    .next_q    (next_q),
    .next_done (next_done),
    .tc        (tc)
  );

  // ---- stage p0: count and DONE registers ----
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      q_p0    <= '0;
      done_p0 <= 1'b0;
    end else begin
      q_p0    <= next_q;
      done_p0 <= next_done;
    end
  end

  assign Q    = q_p0;
  assign DONE = done_p0;
  assign TC   = tc;

endmodule : mod_counter

// File: tb/tb_mod_counter.sv
module tb_mod_counter;

  localparam int M = 14;

  logic       CLK = 1'b0;
  logic       RESET, EN, LOAD, UP, MODE;
  logic [3:0] D;
  logic [3:0] Q;
  logic       TC, DONE;

  // 8-bit binary cascade
  logic       c8_rst, c8_en;
  logic [7:0] lo8_q, hi8_q;
  logic       lo8_tc, hi8_tc, lo8_done, hi8_done;

  // two-decade BCD cascade
  logic       c10_rst, c10_en;
  logic [3:0] lo10_q, hi10_q;
  logic       lo10_tc, hi10_tc, lo10_done, hi10_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mod_counter #(.WIDTH(4), .MAX_VAL(14)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .D(D), .UP(UP),
    .MODE(MODE), .Q(Q), .TC(TC), .DONE(DONE)
  );

  mod_counter #(.WIDTH(8), .MAX_VAL(255)) u_lo8 (
    .CLK(CLK), .RESET(c8_rst), .EN(c8_en), .LOAD(1'b0), .D(8'd0), .UP(1'b1),
    .MODE(1'b0), .Q(lo8_q), .TC(lo8_tc), .DONE(lo8_done)
  );
  mod_counter #(.WIDTH(8), .MAX_VAL(255)) u_hi8 (
    .CLK(CLK), .RESET(c8_rst), .EN(lo8_tc), .LOAD(1'b0), .D(8'd0), .UP(1'b1),
    .MODE(1'b0), .Q(hi8_q), .TC(hi8_tc), .DONE(hi8_done)
  );

  mod_counter #(.WIDTH(4), .MAX_VAL(9)) u_lo10 (
    .CLK(CLK), .RESET(c10_rst), .EN(c10_en), .LOAD(1'b0), .D(4'd0), .UP(1'b1),
    .MODE(1'b0), .Q(lo10_q), .TC(lo10_tc), .DONE(lo10_done)
  );
  mod_counter #(.WIDTH(4), .MAX_VAL(9)) u_hi10 (
    .CLK(CLK), .RESET(c10_rst), .EN(lo10_tc), .LOAD(1'b0), .D(4'd0), .UP(1'b1),
    .MODE(1'b0), .Q(hi10_q), .TC(hi10_tc), .DONE(hi10_done)
  );

  // Behavioural reference: counting is arithmetic modulo (M+1); one-shot
  // saturates at the end of travel and latches a flag.
  function automatic void model_step(input bit rst_n, input bit ld, input bit en,
                                     input bit up, input bit mode, input int d,
                                     input int q_in, input bit done_in,
                                     output int q_out, output bit done_out);
    q_out    = q_in;
    done_out = done_in;
    if (!rst_n) begin
      q_out    = 0;
      done_out = 0;
    end else if (ld) begin
      q_out    = (d > M) ? M : d;
      done_out = 0;
    end else if (en && !(done_in && mode)) begin
      if (up) begin
        if (mode && q_in == M) done_out = 1;
        else                   q_out = (q_in + 1) % (M + 1);
      end else begin
        if (mode && q_in == 0) done_out = 1;
        else                   q_out = (q_in + M) % (M + 1);
      end
    end
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b0; EN = 1'b0; LOAD = 1'b0; D = 4'd0; UP = 1'b1; MODE = 1'b0;
    c8_rst = 1'b0; c8_en = 1'b0; c10_rst = 1'b0; c10_en = 1'b0;
    step();
    step();
    n_checks++;
    if (Q !== 4'd0) begin n_fail++; $display("FAIL reset_q got %0d want 0", Q); end
    n_checks++;
    if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", DONE); end
    n_checks++;
    if (TC !== 1'b0) begin n_fail++; $display("FAIL reset_tc got %b want 0", TC); end
  endtask

  task automatic test_wrap_up();
    int cur;
    RESET = 1'b1; EN = 1'b1; UP = 1'b1; MODE = 1'b0; LOAD = 1'b0;
    cur = 0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      n_checks++;
      if (TC !== (cur == M)) begin
        n_fail++; $display("FAIL wrap_tc q=%0d got %b want %b", cur, TC, cur == M);
      end
      step();
      cur = k % (M + 1);
      n_checks++;
      if (Q !== 4'(cur)) begin n_fail++; $display("FAIL wrap_q edge %0d got %0d want %0d", k, Q, cur); end
      n_checks++;
      if (DONE !== 1'b0) begin n_fail++; $display("FAIL wrap_done edge %0d got %b want 0", k, DONE); end
    end
  endtask

  task automatic test_reset_priority();
    // Q is 1 after the wrap test; six more edges reach 7.
    for (int k = 0; k < 6; k++) step();
    n_checks++;
    if (Q !== 4'd7) begin n_fail++; $display("FAIL pre_reset_q got %0d want 7", Q); end
    RESET = 1'b0; EN = 1'b1; LOAD = 1'b1; D = 4'd9;
    #2;
    n_checks++;
    if (Q !== 4'd7) begin n_fail++; $display("FAIL reset_not_async got %0d want 7", Q); end
    step();
    n_checks++;
    if (Q !== 4'd0) begin n_fail++; $display("FAIL reset_prio_q got %0d want 0", Q); end
    RESET = 1'b1; LOAD = 1'b0;
    step();
    n_checks++;
    if (Q !== 4'd1) begin n_fail++; $display("FAIL resume_q got %0d want 1", Q); end
  endtask

  task automatic test_load_clamp();
    LOAD = 1'b1; D = 4'd15; EN = 1'b0;
    step();
    n_checks++;
    if (Q !== 4'd14) begin n_fail++; $display("FAIL load_clamp got %0d want 14", Q); end
    D = 4'd5; EN = 1'b1;
    step();
    n_checks++;
    if (Q !== 4'd5) begin n_fail++; $display("FAIL load_over_en got %0d want 5", Q); end
    LOAD = 1'b0;
  endtask

  task automatic test_down();
    int exp_seq[4] = '{1, 0, 14, 13};
    int cur;
    LOAD = 1'b1; D = 4'd2; EN = 1'b0;
    step();
    LOAD = 1'b0; UP = 1'b0; MODE = 1'b0; EN = 1'b1;
    cur = 2;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++;
      if (TC !== (cur == 0)) begin
        n_fail++; $display("FAIL down_tc q=%0d got %b want %b", cur, TC, cur == 0);
      end
      step();
      cur = exp_seq[k];
      n_checks++;
      if (Q !== 4'(cur)) begin n_fail++; $display("FAIL down_q step %0d got %0d want %0d", k, Q, cur); end
    end
  endtask

  task automatic test_oneshot();
    LOAD = 1'b1; D = 4'd13; EN = 1'b0; UP = 1'b1; MODE = 1'b1;
    step();
    LOAD = 1'b0; EN = 1'b1;
    step();
    n_checks++;
    if (Q !== 4'd14 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_reach got q=%0d done=%b want q=14 done=0", Q, DONE);
    end
    n_checks++;
    if (TC !== 1'b1) begin n_fail++; $display("FAIL oneshot_tc got %b want 1", TC); end
    step();
    n_checks++;
    if (Q !== 4'd14 || DONE !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_stop got q=%0d done=%b want q=14 done=1", Q, DONE);
    end
    for (int k = 0; k < 3; k++) step();
    n_checks++;
    if (Q !== 4'd14 || DONE !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_hold got q=%0d done=%b want q=14 done=1", Q, DONE);
    end
    // Back to wrap mode: counting resumes, DONE stays set.
    MODE = 1'b0;
    step();
    n_checks++;
    if (Q !== 4'd0 || DONE !== 1'b1) begin
      n_fail++; $display("FAIL oneshot_rewrap got q=%0d done=%b want q=0 done=1", Q, DONE);
    end
    LOAD = 1'b1; D = 4'd3; MODE = 1'b1;
    step();
    n_checks++;
    if (Q !== 4'd3 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_load got q=%0d done=%b want q=3 done=0", Q, DONE);
    end
    LOAD = 1'b0;
  endtask

  task automatic test_random();
    int  mq, nq;
    bit  md, nd;
    bit  exp_tc;
    RESET = 1'b0; LOAD = 1'b0; EN = 1'b0;
    step();
    mq = 0; md = 0;
    for (int k = 0; k < 600; k++) begin
      RESET = ($urandom % 25) != 0;
      LOAD  = ($urandom % 9) == 0;
      EN    = ($urandom % 5) != 0;
      UP    = $urandom % 2;
      if (($urandom % 16) == 0) MODE = ~MODE;
      D     = 4'($urandom % 16);
      #1;
      exp_tc = EN && (UP ? (mq == M) : (mq == 0));
      n_checks++;
      if (TC !== exp_tc) begin
        n_fail++; $display("FAIL rand_tc cycle %0d got %b want %b", k, TC, exp_tc);
      end
      model_step(RESET, LOAD, EN, UP, MODE, int'(D), mq, md, nq, nd);
      step();
      mq = nq; md = nd;
      n_checks++;
      if (Q !== 4'(mq) || DONE !== md) begin
        n_fail++; $display("FAIL rand_state cycle %0d got q=%0d done=%b want q=%0d done=%b",
                           k, Q, DONE, mq, md);
      end
    end
    RESET = 1'b1; LOAD = 1'b0;
  endtask

  task automatic test_cascade8();
    c8_rst = 1'b0;
    step();
    c8_rst = 1'b1; c8_en = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      #1;
      if (k == 256) begin
        n_checks++;
        if (lo8_tc !== 1'b1) begin n_fail++; $display("FAIL c8_tc got %b want 1", lo8_tc); end
      end
      step();
      n_checks++;
      if (lo8_q !== 8'(k % 256) || hi8_q !== 8'(k / 256)) begin
        n_fail++; $display("FAIL c8_count edge %0d got hi=%0d lo=%0d want hi=%0d lo=%0d",
                           k, hi8_q, lo8_q, k / 256, k % 256);
      end
    end
    c8_en = 1'b0;
  endtask

  task automatic test_bcd();
    c10_rst = 1'b0;
    step();
    c10_rst = 1'b1; c10_en = 1'b1;
    for (int k = 1; k <= 105; k++) begin
      step();
      n_checks++;
      if (lo10_q !== 4'(k % 10) || hi10_q !== 4'((k / 10) % 10)) begin
        n_fail++; $display("FAIL bcd_count edge %0d got hi=%0d lo=%0d want hi=%0d lo=%0d",
                           k, hi10_q, lo10_q, (k / 10) % 10, k % 10);
      end
    end
    c10_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_reset_priority();
    test_load_clamp();
    test_down();
    test_oneshot();
    test_random();
    test_cascade8();
    test_bcd();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mod_counter
